// File: rtl/aes_128_inv.sv
// aes_128_inv: iterative AES-128 inverse cipher, one round per clock.
// Round keys are derived on the fly. A forward expansion runs up to round key 10,
// then the inverse key schedule steps back down to round key 0. No round-key storage.
// Optional feature macro: AES_INV_KEY_CACHE_EN. When defined, the last expanded key is kept
// so that a repeat of the same master key skips the forward expansion.
// Handshake: start is sampled only while idle. An accepted start captures ciphertext and master_key.
// busy rises the next cycle and stays high through the final round. done is a one-cycle strobe;
// plaintext is valid from the done cycle until the next accepted start.
module aes_128_inv #(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] master_key,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [2:0]   o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_ARK0  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)) ^ Rcon, the non-linear term of the key schedule.
  function automatic logic [31:0] key_f(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_f(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expansion step: older words are recovered from adjacent newer ones.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ key_f(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows then InvSubBytes; byte index = row + 4*col, byte 0 at [127:120].
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t       r_state;
  logic [3:0]   r_rnd;
  logic [127:0] r_rk;
  logic [127:0] r_st;
  logic [127:0] r_pt;
  logic         r_busy;
  logic         r_done;
`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] r_mkey;
  logic [127:0] r_ck_key;
  logic [127:0] r_ck_rk10;
  logic         r_ck_valid;
`endif

  logic [7:0]   w_rc;
  logic [127:0] w_kfwd;
  logic [127:0] w_kinv;
  logic [127:0] w_isr;

  // r_rnd selects Rcon both going up (KEXP) and coming back down (ARK0/ROUND).
  assign w_rc   = rcon(r_rnd);
  assign w_kfwd = key_fwd(r_rk, w_rc);
  assign w_kinv = key_inv(r_rk, w_rc);
  assign w_isr  = inv_shift_sub(r_st);

  assign plaintext   = r_pt;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

  // Control FSM with datapath and key registers; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rnd   <= 4'd0;
      r_rk    <= '0;
      r_st    <= '0;
      r_pt    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
      r_mkey     <= '0;
      r_ck_key   <= '0;
      r_ck_rk10  <= '0;
      r_ck_valid <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_st   <= ciphertext;
            r_rk   <= master_key;
            r_busy <= 1'b1;
            if (CLEAR_ON_START) r_pt <= '0;
`ifdef AES_INV_KEY_CACHE_EN
            if (r_ck_valid && (master_key == r_ck_key)) begin
              r_rk    <= r_ck_rk10;
              r_rnd   <= 4'd10;
              r_state <= S_ARK0;
            end else begin
              r_mkey  <= master_key;
              r_rnd   <= 4'd1;
              r_state <= S_KEXP;
            end
`else
            r_rnd   <= 4'd1;
            r_state <= S_KEXP;
`endif
          end
        end
        S_KEXP: begin
          r_rk <= w_kfwd;
          if (r_rnd == 4'd10) begin
            r_state <= S_ARK0;
`ifdef AES_INV_KEY_CACHE_EN
            r_ck_key   <= r_mkey;
            r_ck_rk10  <= w_kfwd;
            r_ck_valid <= 1'b1;
`endif
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        S_ARK0: begin
          r_st    <= r_st ^ r_rk;
          r_rk    <= w_kinv;
          r_rnd   <= 4'd9;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_st  <= inv_mix(w_isr ^ r_rk);
          r_rk  <= w_kinv;
          r_rnd <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_pt    <= w_isr ^ r_rk;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_inv.sv
// Testbench for aes_128_inv: FIPS-197 vectors, held start, mid-op reset,
// loopback through a bench-side forward cipher, optional key-cache timing.
`timescale 1ns/1ps
module tb_aes_128_inv;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] master_key = '0;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;
  logic [2:0]   o_dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_128_inv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ciphertext  (ciphertext),
    .master_key  (master_key),
    .plaintext   (plaintext),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (o_dbg_state)
  );

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           n_done = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: every done strobe pops one expected result and its due cycle
  initial begin
    logic         prev_done;
    logic [127:0] e;
    int           ec;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        check("done_single_pulse", 128'(prev_done), 128'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: done at cycle %0d with nothing expected", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("plaintext", plaintext, e);
          check("done_cycle", 128'(cyc), 128'(ec));
        end
      end
      prev_done = done;
    end
  end

  // ---------------- latency model (key cache) ----------------
  logic         m_ck_valid = 1'b0;
  logic [127:0] m_ck_key = '0;

  task automatic lat_model(input logic [127:0] key, output int lat);
`ifdef AES_INV_KEY_CACHE_EN
    if (m_ck_valid && key == m_ck_key) begin
      lat = 11;
    end else begin
      lat = 21;
      m_ck_valid = 1'b1;
      m_ck_key = key;
    end
`else
    lat = 21;
`endif
  endtask

  // ---------------- bench forward cipher ----------------
  logic [7:0] sb[256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box by exhaustive inverse search followed by the affine map
  task automatic build_sbox();
    logic [7:0] x, inv, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gm(x, 8'(j)) == 8'h01) inv = 8'(j);
      s = 8'h63;
      for (int k = 0; k < 5; k++) s = s ^ ((inv << k) | (inv >> (8 - k)));
      sb[i] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] rk, s, t;
    logic [31:0]  tmp, w0, w1, w2, w3;
    logic [7:0]   rc, a0, a1, a2, a3;
    rk = key;
    s  = pt ^ rk;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tmp = {sb[rk[23:16]] ^ rc, sb[rk[15:8]], sb[rk[7:0]], sb[rk[31:24]]};
      w0 = rk[127:96] ^ tmp;
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0] ^ w2;
      rk = {w0, w1, w2, w3};
      rc = xt(rc);
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127-8*(w+4*c) -: 8] = sb[s[127-8*(w+4*((c+w)%4)) -: 8]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8];
          a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8];
          a3 = t[103-32*c -: 8];
          t[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      s = t ^ rk;
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  // called right after a falling edge; start is sampled on the next rising edge
  task automatic issue(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    lat_model(key, lat);
    master_key = key;
    ciphertext = ct;
    start = 1'b1;
    exp_q.push_back(pt);
    exp_cyc_q.push_back(cyc + 1 + lat);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
    check("pt_cleared_on_start", plaintext, 128'd0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results pending after %0d cycles", exp_q.size(), n);
      exp_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int           lat1, lat2, c0, done_before;
    logic [127:0] k, p;

    build_sbox();

    // reset values
    repeat (3) @(negedge clk);
    check("rst_plaintext", plaintext, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_state", 128'(o_dbg_state), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1, then App.B
    issue(KEY_A, CT_A, PT_A);
    wait_drain(40);
    check("pt_hold_after_done", plaintext, PT_A);
    issue(KEY_B, CT_B, PT_B);
    wait_drain(40);

    // start held high; inputs change mid-operation; re-accept on the done cycle
    c0 = cyc;
    lat_model(KEY_A, lat1);
    lat_model(KEY_B, lat2);
    master_key = KEY_A;
    ciphertext = CT_A;
    start = 1'b1;
    exp_q.push_back(PT_A);
    exp_cyc_q.push_back(c0 + 1 + lat1);
    exp_q.push_back(PT_B);
    exp_cyc_q.push_back(c0 + 2 + lat1 + lat2);
    repeat (5) @(negedge clk);
    master_key = KEY_B;
    ciphertext = CT_B;
    repeat (lat1 - 3) @(negedge clk);
    start = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    master_key = {$urandom, $urandom, $urandom, $urandom};
    wait_drain(60);

    // reset in the middle of an operation
    master_key = KEY_A;
    ciphertext = CT_A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    done_before = n_done;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_plaintext", plaintext, 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_state", 128'(o_dbg_state), 128'd0);
    m_ck_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_done", 128'(n_done), 128'(done_before));
    issue(KEY_A, CT_A, PT_A);
    wait_drain(40);

    // loopback through the bench forward cipher
    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      issue(k, aes_enc(k, p), p);
      wait_drain(40);
    end

    // same key twice (cache hit when enabled), then a different key
    issue(KEY_A, CT_A, PT_A);
    wait_drain(40);
    issue(KEY_A, CT_A, PT_A);
    wait_drain(40);
    issue(KEY_B, CT_B, PT_B);
    wait_drain(40);

    check("pending_results", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
